// File: rtl/matrix_result_streamer.sv
// Streams an NxN result matrix out of a 1-cycle-latency memory in row-major
// order through a 2-entry output FIFO with a valid/ready handshake.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, n_size          stream request and matrix dimension N (1..MAX_SIZE)
//   busy, done, err        status: stream active, completion pulse, bad-N pulse
//   rd_en, rd_row, rd_col  read request to result memory
//   rd_data                memory data, valid one cycle after rd_en
//   out_data, out_valid, out_ready, out_eol, out_last  output stream
module matrix_result_streamer #(
  parameter int unsigned MAX_SIZE = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned IDX_W    = $clog2(MAX_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W:0]    n_size,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_row,
  output logic [IDX_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_last
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    n_q;
  logic [IDX_W-1:0]    row_q;
  logic [IDX_W-1:0]    col_q;
  logic                done_q;
  logic                err_q;
  // Read issued last cycle: its data is on rd_data now, tags ride alongside.
  logic                rd_v_q;
  logic                rd_eol_q;
  logic                rd_last_q;
  logic [DATA_W-1:0]   fifo_data_q [2];
  logic [1:0]          fifo_eol_q;
  logic [1:0]          fifo_last_q;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  logic                pop;
  logic                push;
  logic                col_end;
  logic                row_end;
  logic                n_ok;
  logic [2:0]          occupancy;

  assign n_ok    = (n_size != '0) && (n_size <= CNT_W'(MAX_SIZE));
  assign col_end = ({1'b0, col_q} == (n_q - CNT_W'(1)));
  assign row_end = ({1'b0, row_q} == (n_q - CNT_W'(1)));

  assign out_valid = (count_q != 2'd0);
  assign out_data  = fifo_data_q[rd_ptr_q];
  assign out_eol   = fifo_eol_q[rd_ptr_q];
  assign out_last  = fifo_last_q[rd_ptr_q];
  assign pop       = out_valid && out_ready;
  assign push      = rd_v_q;

  // Credit check: entries held plus data already on its way, minus what
  // leaves this cycle, must leave a free slot for the new read.
  assign occupancy = 3'(count_q) + 3'(rd_v_q) - 3'(pop);
  assign rd_en     = (state_q == STREAM) && (occupancy < 3'd2);

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign rd_row = row_q;
  assign rd_col = col_q;

  // Control FSM, read pipeline and output FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      row_q          <= '0;
      col_q          <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      rd_v_q         <= 1'b0;
      rd_eol_q       <= 1'b0;
      rd_last_q      <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_eol_q     <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_v_q    <= rd_en;
      rd_eol_q  <= col_end;
      rd_last_q <= col_end && row_end;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data;
        fifo_eol_q[wr_ptr_q]  <= rd_eol_q;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);

      case (state_q)
        IDLE: begin
          if (start) begin
            if (n_ok) begin
              n_q     <= n_size;
              row_q   <= '0;
              col_q   <= '0;
              state_q <= STREAM;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (rd_en) begin
            if (col_end) begin
              // Final element requested: keep indices, just wait for drain.
              if (row_end) begin
                state_q <= DRAIN;
              end else begin
                row_q <= row_q + IDX_W'(1);
                col_q <= '0;
              end
            end else begin
              col_q <= col_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a memory model C[i][j]=10*i+j.
module tb_matrix_result_streamer;

  localparam int unsigned MAX_SIZE = 16;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W:0]    n_size;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_row;
  logic [IDX_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_eol;
  logic              out_last;

  matrix_result_streamer #(.MAX_SIZE(MAX_SIZE), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_size(n_size),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_eol(out_eol), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Result memory: one-cycle read latency.
  always @(posedge clk) begin
    rd_data <= rd_en ? 32'(10 * int'(rd_row) + int'(rd_col)) : 32'hDEADBEEF;
  end

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int rden_cnt = 0;
  logic [33:0] got[$];
  logic        stalled = 1'b0;
  logic [33:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, observe mid-cycle.
  task automatic cyc(input logic r, input logic st, input logic [IDX_W:0] n, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; start = st; n_size = n; out_ready = rdy;
    #1;
    if (stalled) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({out_last, out_eol, out_data}), 64'(held));
    end
    stalled = !r && out_valid && !out_ready;
    held = {out_last, out_eol, out_data};
    if (out_valid && out_ready) got.push_back({out_last, out_eol, out_data});
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rd_en) rden_cnt++;
  endtask

  task automatic drain(input string tag, input int budget, input bit rnd);
    int i;
    i = 0;
    while (!done && i < budget) begin
      cyc(1'b0, 1'b0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      i++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic check_stream(input string tag, input int n);
    logic [33:0] exp;
    chk({tag, "_count"}, 64'(got.size()), 64'(n * n));
    for (int k = 0; k < got.size() && k < n * n; k++) begin
      exp = {k == n * n - 1, (k % n) == n - 1, 32'(10 * (k / n) + (k % n))};
      chk($sformatf("%s_w%0d", tag, k), 64'(got[k]), 64'(exp));
    end
  endtask

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; n_size = '0; out_ready = 1'b1;

    // Reset state
    cyc(1'b1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 5'd2, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("reset_outputs", 64'({busy, done, err, rd_en, out_valid, out_eol, out_last,
                              rd_row, rd_col, out_data}), 64'd0);

    // N=2 cycle-accurate walk
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd2, 1'b1);                         // cycle 0
    chk("n2_c0_busy", 64'(busy), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 1
    chk("n2_c1_busy", 64'(busy), 64'd1);
    chk("n2_c1_rd", 64'({rd_en, rd_row, rd_col}), 64'({1'b1, 4'd0, 4'd0}));
    chk("n2_c1_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 2
    chk("n2_c2_rd", 64'({rd_en, rd_row, rd_col}), 64'({1'b1, 4'd0, 4'd1}));
    chk("n2_c2_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 3
    chk("n2_c3_out", 64'({out_valid, out_eol, out_last, out_data}), 64'({3'b100, 32'd0}));
    chk("n2_c3_rd", 64'({rd_en, rd_row, rd_col}), 64'({1'b1, 4'd1, 4'd0}));
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 4
    chk("n2_c4_out", 64'({out_valid, out_eol, out_last, out_data}), 64'({3'b110, 32'd1}));
    chk("n2_c4_rd", 64'({rd_en, rd_row, rd_col}), 64'({1'b1, 4'd1, 4'd1}));
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 5
    chk("n2_c5_out", 64'({out_valid, out_eol, out_last, out_data}), 64'({3'b100, 32'd10}));
    chk("n2_c5_rden", 64'(rd_en), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 6
    chk("n2_c6_out", 64'({out_valid, out_eol, out_last, out_data}), 64'({3'b111, 32'd11}));
    chk("n2_c6_done", 64'(done), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 7
    chk("n2_c7_status", 64'({out_valid, done, busy}), 64'({1'b0, 1'b1, 1'b0}));
    cyc(1'b0, 1'b0, '0, 1'b1);                           // cycle 8
    chk("n2_c8_done", 64'(done), 64'd0);
    check_stream("n2", 2);

    // Illegal sizes
    rden_cnt = 0; err_cnt = 0;
    cyc(1'b0, 1'b1, 5'd0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("n0_err", 64'({err, busy, rd_en}), 64'({1'b1, 1'b0, 1'b0}));
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("n0_err_clear", 64'({err, busy}), 64'd0);
    cyc(1'b0, 1'b1, 5'd17, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("n17_err", 64'({err, busy, rd_en}), 64'({1'b1, 1'b0, 1'b0}));
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("n17_err_clear", 64'({err, busy}), 64'd0);
    chk("bad_n_rden", 64'(rden_cnt), 64'd0);
    chk("bad_n_errcnt", 64'(err_cnt), 64'd2);

    // N=4 with a 5-cycle stall after the third word
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd4, 1'b1);
    i = 0;
    while (got.size() < 3 && i < 20) begin cyc(1'b0, 1'b0, '0, 1'b1); i++; end
    chk("s4_reach3", 64'(got.size()), 64'd3);
    rden_cnt = 0;
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b0);
    chk("s4_stall_rden", 64'(rden_cnt), 64'd0);
    drain("s4", 100, 1'b0);
    check_stream("s4", 4);
    chk("s4_done_cnt", 64'(done_cnt), 64'd1);

    // N=4 with a second start mid-stream
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd4, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b1, 5'd3, 1'b1);
    drain("restart", 100, 1'b0);
    check_stream("restart", 4);
    chk("restart_done_cnt", 64'(done_cnt), 64'd1);

    // Reset after the fifth word, with start in the same cycle
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd4, 1'b1);
    i = 0;
    while (got.size() < 5 && i < 20) begin cyc(1'b0, 1'b0, '0, 1'b1); i++; end
    chk("rst_reach5", 64'(got.size()), 64'd5);
    cyc(1'b1, 1'b1, 5'd4, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_mid_outputs", 64'({busy, done, err, rd_en, out_valid, out_eol, out_last,
                                rd_row, rd_col, out_data}), 64'd0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("rst_drop_late_data", 64'({out_valid, busy}), 64'd0);
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd2, 1'b1);
    drain("after_rst", 50, 1'b0);
    check_stream("after_rst", 2);

    // N=1 single word
    got.delete(); done_cnt = 0;
    cyc(1'b0, 1'b1, 5'd1, 1'b1);
    drain("n1", 20, 1'b0);
    check_stream("n1", 1);

    // N=16 with random backpressure
    got.delete(); done_cnt = 0; err_cnt = 0;
    cyc(1'b0, 1'b1, 5'd16, 1'b1);
    drain("n16", 3000, 1'b1);
    check_stream("n16", 16);
    cyc(1'b0, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    chk("n16_done_cnt", 64'(done_cnt), 64'd1);
    chk("n16_err_cnt", 64'(err_cnt), 64'd0);
    chk("n16_idle", 64'({busy, out_valid}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
